// File: rtl/bin2bcd_seq_ctrl.sv
// Sequential binary-to-BCD converter: MSB-first double-and-add over a chain
// of per-digit decimal cells, valid/ready on both sides, no pipelining.

// One decimal digit: s = 2*digit + carryIn, corrected back into 0..9.
module bin2bcdDigit (
  input  logic [3:0] digit,
  input  logic       carryIn,
  output logic [3:0] digitNext,
  output logic       carryOut
);
  logic [4:0] sum;

  assign sum = {digit, carryIn};

  // Decimal correction: anything 10..19 wraps and carries into the next digit.
  always_comb begin
    digitNext = sum[3:0];
    carryOut  = 1'b0;
    if (sum > 5'd9) begin
      digitNext = 4'(sum - 5'd10);
      carryOut  = 1'b1;
    end
  end
endmodule

module bin2bcd_seq_ctrl #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic                  overflow,
  output logic                  busy
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t                  state, nextState;
  logic [WIDTH-1:0]        shiftReg;
  logic [CW-1:0]           bitCnt;
  logic [DIGITS-1:0][3:0]  digitReg;
  logic [DIGITS-1:0][3:0]  digitNext;
  logic [DIGITS:0]         carry;
  logic                    ovfReg;
  logic                    lastStep;

  // The binary MSB enters the units digit as its carry-in.
  assign carry[0] = shiftReg[WIDTH-1];

  for (genvar k = 0; k < DIGITS; k++) begin : gDigit
    bin2bcdDigit uDigit (
      .digit     (digitReg[k]),
      .carryIn   (carry[k]),
      .digitNext (digitNext[k]),
      .carryOut  (carry[k+1])
    );
  end

  assign lastStep = (bitCnt == CW'(1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  // Next-state: accept in IDLE, run WIDTH steps, hold result until taken.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (in_valid) nextState = CONV;
      CONV:    if (lastStep) nextState = DONE;
      DONE:    if (out_ready) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Datapath: load on accept, one double-and-add step per CONV cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      shiftReg <= '0;
      bitCnt   <= '0;
      digitReg <= '0;
      ovfReg   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          shiftReg <= in_data;
          bitCnt   <= CW'(WIDTH);
          digitReg <= '0;
          ovfReg   <= 1'b0;
        end
        CONV: begin
          shiftReg <= shiftReg << 1;
          bitCnt   <= bitCnt - CW'(1);
          digitReg <= digitNext;
          ovfReg   <= ovfReg | carry[DIGITS];
        end
        default: ;
      endcase
    end
  end

  // Status outputs decode from state only; data outputs come from registers.
  assign in_ready  = (state == IDLE);
  assign busy      = (state == CONV);
  assign out_valid = (state == DONE);
  assign out_bcd   = digitReg;
  assign overflow  = ovfReg;
endmodule
